// File: rtl/snn_bridge_pkg.sv
// Shared constants, marker FSM state type and marker word builder for the
// AXI4-Stream <-> SNN core spike bridge.
package snn_bridge_pkg;

  localparam int MARKER_BIT     = 31;
  localparam int ID_LSB         = 16;
  localparam int STEP_W         = 16;
  localparam int CNT_W          = 32;

  localparam int ERR_ID_RANGE   = 0;
  localparam int ERR_MARKER_OVR = 1;
  localparam int ERR_RSVD       = 2;

  typedef enum logic {
    MK_IDLE    = 1'b0,
    MK_PENDING = 1'b1
  } marker_state_e;

  function automatic logic [31:0] marker_word(input logic [STEP_W-1:0] step);
    marker_word             = '0;
    marker_word[MARKER_BIT] = 1'b1;
    marker_word[STEP_W-1:0] = step;
  endfunction

endpackage

// File: rtl/snn_axis_spike_bridge_if.sv
// 32-bit AXI4-Stream bundle; master drives data/valid/last, slave drives ready.
interface snn_axis_spike_bridge_if;

  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);

endinterface

// File: rtl/spike_sync_fifo.sv
// Single-clock FIFO with pointer-based full/empty; the head word is read from
// registered storage, so a word pushed in cycle N is visible in cycle N+1.
module spike_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_en;
  logic             pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which
  // entries are live, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/snn_axis_spike_bridge.sv
// AXI4-Stream to SNN core spike bridge: ingress/egress FIFOs, neuron ID range
// check, per-timestep egress marker framing, spike counters and sticky errors.
module snn_axis_spike_bridge
  import snn_bridge_pkg::*;
#(
  parameter int NEURON_ID_W = 10,
  parameter int WEIGHT_W    = 8,
  parameter int NUM_NEURONS = 1024,
  parameter int IN_DEPTH    = 16,
  parameter int OUT_DEPTH   = 32
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  snn_axis_spike_bridge_if.slave     s_axis_spikes,
  snn_axis_spike_bridge_if.master    m_axis_spikes,
  output logic                       spike_in_valid,
  input  logic                       spike_in_ready,
  output logic [NEURON_ID_W-1:0]     spike_in_neuron_id,
  output logic [WEIGHT_W-1:0]        spike_in_weight,
  input  logic                       spike_out_valid,
  output logic                       spike_out_ready,
  input  logic [NEURON_ID_W-1:0]     spike_out_neuron_id,
  input  logic [WEIGHT_W-1:0]        spike_out_weight,
  input  logic                       timestep_end,
  output logic                       timestep_tick,
  input  logic                       clear_counters,
  output logic [CNT_W-1:0]           in_spike_count,
  output logic [CNT_W-1:0]           out_spike_count,
  output logic [STEP_W-1:0]          step_count,
  output logic [2:0]                 err_status
);

  localparam int CORE_W = NEURON_ID_W + WEIGHT_W;
  localparam int EG_W   = 33;

  // Holds both ready outputs low for the first cycle out of reset.
  logic ready_q;

  // ---------------- ingress ----------------
  logic [NEURON_ID_W-1:0] rx_id;
  logic [WEIGHT_W-1:0]    rx_weight;
  logic                   rx_accept, rx_marker, rx_in_range, rx_push, rx_err;
  logic                   in_full, in_empty;
  logic [CORE_W-1:0]      in_rdata;
  logic                   tick_q;
  logic                   unused_rx;

  assign rx_id       = s_axis_spikes.TDATA[ID_LSB +: NEURON_ID_W];
  assign rx_weight   = s_axis_spikes.TDATA[0 +: WEIGHT_W];
  assign rx_marker   = s_axis_spikes.TDATA[MARKER_BIT];
  assign rx_accept   = s_axis_spikes.TVALID && s_axis_spikes.TREADY;
  assign rx_in_range = (32'(rx_id) < 32'(NUM_NEURONS));
  assign rx_push     = rx_accept && !rx_marker && rx_in_range;
  assign rx_err      = rx_accept && !rx_marker && !rx_in_range;
  assign unused_rx   = ^{s_axis_spikes.TLAST, s_axis_spikes.TDATA};

  assign s_axis_spikes.TREADY = ready_q && !in_full;

  spike_sync_fifo #(.WIDTH(CORE_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push_i  (rx_push),
    .wdata_i ({rx_id, rx_weight}),
    .pop_i   (spike_in_valid && spike_in_ready),
    .rdata_o (in_rdata),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  assign spike_in_valid     = !in_empty;
  assign spike_in_neuron_id = in_rdata[WEIGHT_W +: NEURON_ID_W];
  assign spike_in_weight    = in_rdata[0 +: WEIGHT_W];
  assign timestep_tick      = tick_q;

  // ---------------- egress + marker FSM ----------------
  marker_state_e      state_q, state_d;
  logic               marker_write, tx_spike, err_ovr;
  logic [EG_W-1:0]    tx_word, out_rdata;
  logic               out_full, out_empty;
  logic [STEP_W-1:0]  step_q, step_d;

  assign spike_out_ready = ready_q && !out_full && (state_q == MK_IDLE);
  assign tx_spike        = spike_out_valid && spike_out_ready;
  assign err_ovr         = timestep_end && (state_q == MK_PENDING);

  // NOTE: every signal assigned in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    marker_write = 1'b0;
    unique case (state_q)
      MK_IDLE:    if (timestep_end) state_d = MK_PENDING;
      MK_PENDING: if (!out_full) begin
        marker_write = 1'b1;
        state_d      = MK_IDLE;
      end
    endcase
  end

  always_comb begin
    tx_word = '0;
    if (marker_write) begin
      tx_word = {1'b1, marker_word(step_q)};
    end else begin
      tx_word[ID_LSB +: NEURON_ID_W] = spike_out_neuron_id;
      tx_word[0 +: WEIGHT_W]         = spike_out_weight;
    end
  end

  spike_sync_fifo #(.WIDTH(EG_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .push_i  (tx_spike || marker_write),
    .wdata_i (tx_word),
    .pop_i   (m_axis_spikes.TVALID && m_axis_spikes.TREADY),
    .rdata_o (out_rdata),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  assign m_axis_spikes.TVALID = !out_empty;
  assign m_axis_spikes.TDATA  = out_rdata[31:0];
  assign m_axis_spikes.TLAST  = out_rdata[32] && !out_empty;

  // ---------------- counters and sticky errors ----------------
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [1:0]       err_q, err_d;

  always_comb begin
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    step_d    = step_q;
    err_d     = err_q;
    if (rx_push)      in_cnt_d  = in_cnt_q + 1'b1;
    if (tx_spike)     out_cnt_d = out_cnt_q + 1'b1;
    if (marker_write) step_d    = step_q + 1'b1;
    if (rx_err)       err_d[ERR_ID_RANGE]   = 1'b1;
    if (err_ovr)      err_d[ERR_MARKER_OVR] = 1'b1;
    // Clearing wins over any same-cycle increment or error.
    if (clear_counters) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
      step_d    = '0;
      err_d     = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ready_q   <= 1'b0;
      tick_q    <= 1'b0;
      state_q   <= MK_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      step_q    <= '0;
      err_q     <= '0;
    end else begin
      ready_q   <= 1'b1;
      tick_q    <= rx_accept && rx_marker;
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      step_q    <= step_d;
      err_q     <= err_d;
    end
  end

  assign in_spike_count                          = in_cnt_q;
  assign out_spike_count                         = out_cnt_q;
  assign step_count                              = step_q;
  assign err_status[ERR_MARKER_OVR:ERR_ID_RANGE] = err_q;
  assign err_status[ERR_RSVD]                    = 1'b0;

endmodule

// File: tb/tb_snn_axis_spike_bridge.sv
// Scoreboard bench for snn_axis_spike_bridge: directed stimulus pushes expected
// core/egress words into queues; negedge monitors pop and compare.
module tb_snn_axis_spike_bridge;

  localparam int ID_W = 11;
  localparam int W_W  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snn_axis_spike_bridge_if s_if ();
  snn_axis_spike_bridge_if m_if ();

  logic            spike_in_valid, spike_in_ready;
  logic [ID_W-1:0] in_id;
  logic [W_W-1:0]  in_w;
  logic            spike_out_valid, spike_out_ready;
  logic [ID_W-1:0] out_id;
  logic [W_W-1:0]  out_w;
  logic            timestep_end, timestep_tick, clear_counters;
  logic [31:0]     in_cnt, out_cnt;
  logic [15:0]     step_cnt;
  logic [2:0]      err;

  snn_axis_spike_bridge #(
    .NEURON_ID_W (ID_W),
    .WEIGHT_W    (W_W),
    .NUM_NEURONS (1024),
    .IN_DEPTH    (16),
    .OUT_DEPTH   (32)
  ) dut (
    .ap_clk              (clk),
    .ap_rst_n            (rst_n),
    .s_axis_spikes       (s_if),
    .m_axis_spikes       (m_if),
    .spike_in_valid      (spike_in_valid),
    .spike_in_ready      (spike_in_ready),
    .spike_in_neuron_id  (in_id),
    .spike_in_weight     (in_w),
    .spike_out_valid     (spike_out_valid),
    .spike_out_ready     (spike_out_ready),
    .spike_out_neuron_id (out_id),
    .spike_out_weight    (out_w),
    .timestep_end        (timestep_end),
    .timestep_tick       (timestep_tick),
    .clear_counters      (clear_counters),
    .in_spike_count      (in_cnt),
    .out_spike_count     (out_cnt),
    .step_count          (step_cnt),
    .err_status          (err)
  );

  int checks = 0;
  int errors = 0;

  logic [ID_W+W_W-1:0] exp_core [$];
  logic [32:0]         exp_eg   [$];
  logic [ID_W+W_W-1:0] core_e;
  logic [32:0]         eg_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] spike_word(input logic [ID_W-1:0] id, input logic [W_W-1:0] w);
    spike_word = (32'(id) << 16) | 32'(w);
  endfunction

  // Core-side monitor: one pop per spike_in handshake.
  always @(negedge clk) begin
    if (rst_n && spike_in_valid && spike_in_ready) begin
      if (exp_core.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL core_extra: got id=%0d w=0x%0h, expected no word", in_id, in_w);
      end else begin
        core_e = exp_core.pop_front();
        check("core_word", {in_id, in_w}, core_e);
      end
    end
  end

  // Egress monitor: compares {TLAST, TDATA} per handshake.
  always @(negedge clk) begin
    if (rst_n && m_if.TVALID && m_if.TREADY) begin
      if (exp_eg.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL egress_extra: got last=%0b data=0x%08h, expected no word", m_if.TLAST, m_if.TDATA);
      end else begin
        eg_e = exp_eg.pop_front();
        check("egress_word", {m_if.TLAST, m_if.TDATA}, eg_e);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axis_send(input logic [31:0] d);
    logic done;
    int   budget;
    done   = 1'b0;
    budget = 0;
    s_if.TDATA  = d;
    s_if.TVALID = 1'b1;
    while (!done && budget < 100) begin
      @(negedge clk);
      if (s_if.TREADY) done = 1'b1;
      @(posedge clk);
      #1;
      budget++;
    end
    s_if.TVALID = 1'b0;
    check("axis_send_accepted", done, 1);
  endtask

  task automatic core_send(input logic [ID_W-1:0] id, input logic [W_W-1:0] w);
    logic done;
    int   budget;
    done   = 1'b0;
    budget = 0;
    out_id = id;
    out_w  = w;
    spike_out_valid = 1'b1;
    while (!done && budget < 100) begin
      @(negedge clk);
      if (spike_out_ready) done = 1'b1;
      @(posedge clk);
      #1;
      budget++;
    end
    spike_out_valid = 1'b0;
    check("core_send_accepted", done, 1);
  endtask

  task automatic pulse_te();
    timestep_end = 1'b1;
    cyc(1);
    timestep_end = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_core.size() != 0 || exp_eg.size() != 0) && n < 500) begin
      cyc(1);
      n++;
    end
    check(name, exp_core.size() + exp_eg.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  acc;
    logic tr;
    s_if.TDATA = '0;  s_if.TVALID = 1'b0;  s_if.TLAST = 1'b0;
    m_if.TREADY = 1'b1;
    spike_in_ready = 1'b1;
    spike_out_valid = 1'b0;  out_id = '0;  out_w = '0;
    timestep_end = 1'b0;  clear_counters = 1'b0;

    // Reset state
    #12;
    check("rst_s_tready",    s_if.TREADY, 0);
    check("rst_in_valid",    spike_in_valid, 0);
    check("rst_out_ready",   spike_out_ready, 0);
    check("rst_m_tvalid",    m_if.TVALID, 0);
    check("rst_m_tlast",     m_if.TLAST, 0);
    check("rst_tick",        timestep_tick, 0);
    check("rst_counts",      {in_cnt, out_cnt}, 0);
    check("rst_step_err",    {step_cnt, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_s_tready",  s_if.TREADY, 1);
    check("post_rst_out_ready", spike_out_ready, 1);

    // Two in-range spikes, including the top ID 1023
    exp_core.push_back({11'd5, 8'h12});
    exp_core.push_back({11'd1023, 8'hFF});
    axis_send(32'h0005_0012);
    axis_send(32'h03FF_00FF);
    wait_drain("drain_ingress_basic");
    check("in_cnt_2", in_cnt, 2);

    // ID 1024 is out of range: dropped, sticky error
    axis_send(32'h0400_0000);
    cyc(2);
    check("oor_err",       err, 3'b001);
    check("oor_no_fwd",    spike_in_valid, 0);
    check("oor_cnt_same",  in_cnt, 2);

    // Clear coincides with an accepted spike: counter and error end at 0
    exp_core.push_back({11'd1, 8'h01});
    clear_counters = 1'b1;
    axis_send(32'h0001_0001);
    clear_counters = 1'b0;
    check("clr_err", err, 0);
    check("clr_in_cnt", in_cnt, 0);
    wait_drain("drain_after_clear");

    // Ingress backpressure: FIFO absorbs exactly 16 words
    spike_in_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 25; i++) begin
      s_if.TVALID = 1'b1;
      s_if.TDATA  = spike_word(11'(100 + acc), 8'(3 * acc + 1));
      @(negedge clk);
      tr = s_if.TREADY;
      @(posedge clk);
      #1;
      if (tr) begin
        exp_core.push_back({11'(100 + acc), 8'(3 * acc + 1)});
        acc++;
      end
    end
    s_if.TVALID = 1'b0;
    check("bp_accepted", acc, 16);
    check("bp_tready_low", s_if.TREADY, 0);
    spike_in_ready = 1'b1;
    wait_drain("drain_bp_ingress");
    check("bp_in_cnt", in_cnt, 16);

    // Egress: three spikes then a framed marker
    exp_eg.push_back({1'b0, 32'h0007_0011});
    exp_eg.push_back({1'b0, 32'h03FF_0080});
    exp_eg.push_back({1'b0, 32'h0000_0000});
    exp_eg.push_back({1'b1, 32'h8000_0000});
    core_send(11'd7, 8'h11);
    core_send(11'd1023, 8'h80);
    core_send(11'd0, 8'h00);
    pulse_te();
    wait_drain("drain_step0");
    check("step_1", step_cnt, 1);
    check("out_cnt_3", out_cnt, 3);

    // Spike and timestep_end in the same cycle
    exp_eg.push_back({1'b0, 32'h002A_005A});
    exp_eg.push_back({1'b1, 32'h8000_0001});
    out_id = 11'd42;  out_w = 8'h5A;
    spike_out_valid = 1'b1;
    timestep_end = 1'b1;
    @(negedge clk);
    check("same_cycle_ready", spike_out_ready, 1);
    @(posedge clk);
    #1;
    spike_out_valid = 1'b0;
    timestep_end = 1'b0;
    check("marker_cycle_ready", spike_out_ready, 0);
    wait_drain("drain_step1");
    check("step_2", step_cnt, 2);
    check("out_cnt_4", out_cnt, 4);

    // Egress full, two timestep_end pulses: one marker, overrun flagged
    m_if.TREADY = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_eg.push_back({1'b0, spike_word(11'(200 + i), 8'(i))});
      core_send(11'(200 + i), 8'(i));
    end
    check("full_out_ready", spike_out_ready, 0);
    check("full_head", {m_if.TVALID, m_if.TLAST, m_if.TDATA}, {2'b10, 32'h00C8_0000});
    exp_eg.push_back({1'b1, 32'h8000_0002});
    pulse_te();
    cyc(1);
    pulse_te();
    check("ovr_err", err, 3'b010);
    check("ovr_out_ready", spike_out_ready, 0);
    check("stall_head_stable", {m_if.TLAST, m_if.TDATA}, {1'b0, 32'h00C8_0000});
    m_if.TREADY = 1'b1;
    wait_drain("drain_full");
    cyc(3);
    check("step_3", step_cnt, 3);
    check("out_cnt_36", out_cnt, 36);
    check("ready_back", spike_out_ready, 1);

    // Ingress marker: single-cycle tick, nothing forwarded
    axis_send(32'h8000_0007);
    check("tick_high", timestep_tick, 1);
    check("tick_no_fwd", spike_in_valid, 0);
    cyc(1);
    check("tick_single", timestep_tick, 0);
    check("tick_in_cnt", in_cnt, 16);

    // Asynchronous reset mid-burst
    spike_in_ready = 1'b0;
    m_if.TREADY = 1'b0;
    axis_send(32'h0003_0003);
    core_send(11'd9, 8'h09);
    pulse_te();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_valid", spike_in_valid, 0);
    check("arst_m_tvalid", {m_if.TVALID, m_if.TLAST}, 0);
    check("arst_counts", {out_cnt, step_cnt, err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    spike_in_ready = 1'b1;
    m_if.TREADY = 1'b1;
    cyc(10);
    check("arst_s_tready", s_if.TREADY, 1);
    check("arst_in_cnt", in_cnt, 0);
    check("arst_quiet", {spike_in_valid, m_if.TVALID}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snn_axis_spike_bridge.md
# snn_axis_spike_bridge

Hand-written, parametrised AXI4-Stream to core spike bridge. It replaces the fixed-width HLS spike path between the PS DMA streams and the RTL SNN core. It buffers ingress and egress spikes in independent FIFOs, range-checks neuron IDs, and frames egress traffic per timestep with a marker word and TLAST. It also provides the spike counters and error status the HLS path left tied off.

## Interface
Parameters:
- NEURON_ID_W, 10: neuron ID width (1..15)
- WEIGHT_W, 8: weight width (1..16)
- NUM_NEURONS, 1024: valid IDs are 0..NUM_NEURONS-1
- IN_DEPTH, 16: ingress FIFO depth, power of two ≥2
- OUT_DEPTH, 32: egress FIFO depth, power of two ≥2

Ports:
- ap_clk  in  1  clock; all logic is single-clock
- ap_rst_n  in  1  asynchronous, active-low reset
- s_axis_spikes_TDATA/TVALID/TREADY  in/in/out  32/1/1  ingress spike words
- m_axis_spikes_TDATA/TVALID/TREADY/TLAST  out/out/in/out  32/1/1/1  egress spike words
- spike_in_valid/spike_in_ready  out/in  1/1  handshake to the core
- spike_in_neuron_id  out  NEURON_ID_W  neuron ID to the core
- spike_in_weight  out  WEIGHT_W  weight to the core
- spike_out_valid/spike_out_ready  in/out  1/1  handshake from the core
- spike_out_neuron_id  in  NEURON_ID_W  neuron ID from the core
- spike_out_weight  in  WEIGHT_W  weight from the core
- timestep_end  in  1  single-cycle pulse from the core: the current step is complete
- timestep_tick  out  1  single-cycle pulse when an ingress marker word is consumed
- clear_counters  in  1  synchronous clear of the counters and sticky errors
- in_spike_count, out_spike_count  out  32  forwarded-spike counters; wrap at 2^32
- step_count  out  16  number of emitted egress markers; wraps
- err_status  out  3  sticky: [0] ID out of range, [1] marker overrun, [2] reserved, always 0

## Operation
- Word format:
  - bit31=0 is a spike word: ID in [16 +: NEURON_ID_W], weight in [0 +: WEIGHT_W]; all other bits are 0 on egress and ignored on ingress.
  - bit31=1 is a marker word: {1, 15'b0, step[15:0]}.
- Ingress:
  - s_axis_spikes_TREADY = !in_fifo_full.
  - An accepted spike word with ID < NUM_NEURONS is written to the ingress FIFO and increments in_spike_count.
  - An accepted spike word with ID ≥ NUM_NEURONS is dropped and sets err_status[0].
  - An accepted marker word is not forwarded; it pulses timestep_tick in the cycle after acceptance.
- Ingress FIFO head drives spike_in_*. A pop happens on spike_in_valid && spike_in_ready.
- Egress:
  - spike_out_ready = !out_fifo_full && !marker_pending.
  - A handshaken spike is written as a spike word and increments out_spike_count.
- Marker insertion:
  - timestep_end sets marker_pending.
  - While marker_pending is set and the egress FIFO is not full, the marker {1, 15'b0, step_count} is written with a TLAST tag, then step_count increments and marker_pending clears.
  - timestep_end arriving while marker_pending is already set sets err_status[1]; that second marker is lost.
- Egress FIFO entries carry {tlast, data[31:0]}. m_axis_spikes_TLAST is 1 only on marker words.
- Counters and step_count are never saturated; they wrap.

## Timing
- Reset values:
  - TREADY, spike_in_valid, spike_out_ready, m_axis_spikes_TVALID, TLAST, timestep_tick: all 0.
  - All counters, err_status and marker_pending: 0.
  - TREADY and spike_out_ready rise in the first cycle after reset is released.
- Ingress latency: a word accepted at cycle N gives spike_in_valid at N+1 (registered FIFO output, no fall-through). The same applies from spike_out to m_axis TVALID.
- Full throughput of one word per cycle per direction. A simultaneous push and pop on a full FIFO is not allowed: TREADY is already low when the FIFO is full.
- A simultaneous spike_out handshake and timestep_end in cycle N: the spike is written at N; the marker is written at N+1 at the earliest, and spike_out_ready is 0 in N+1.
- A marker blocked by a full egress FIFO waits; spike_out_ready stays 0 until the marker is written.
- clear_counters takes priority over a same-cycle increment or error: the result is 0. step_count is also cleared.
- Outputs hold stable under backpressure: TDATA/TLAST stay constant while TVALID && !TREADY.
- An asynchronous reset mid-burst empties both FIFOs and drops any pending marker; no partial word is emitted afterwards.

## Structure
- Shared package/include `snn_bridge_pkg` holds MARKER_BIT=31, ID_LSB=16 and the err_status bit indices.
- One reusable sub-module `spike_sync_fifo` (params WIDTH, DEPTH): registered output, full/empty flags, pointers one bit wider than log2(DEPTH). It is instantiated twice, with WIDTH = NEURON_ID_W+WEIGHT_W and 33.
- The top level holds the marker FSM: IDLE → PENDING on timestep_end; PENDING → IDLE when the marker is written.

## Test plan
- Reset, then send spike words 0x0005_0012 and 0x03FF_00FF → core sees (ID 5, weight 0x12) then (ID 1023, weight 0xFF); in_spike_count=2.
- Send ID 0x0400 with NUM_NEURONS=1024 → nothing forwarded, err_status=3'b001; then clear_counters → err_status=0 and in_spike_count=0.
- Hold spike_in_ready=0 and stream 20 words with IN_DEPTH=16 → TREADY drops after 16 accepts; release → all 16 delivered in order with no loss.
- Core emits 3 spikes, then timestep_end → 4 egress words, the last being 0x8000_0000 with TLAST=1; step_count=1. The next step's marker is 0x8000_0001.
- Hold m_axis TREADY=0 until the egress FIFO is full, then pulse timestep_end twice → spike_out_ready=0 and err_status[1]=1; after release exactly one marker appears.
- Ingress marker word 0x8000_0007 → timestep_tick is 1 for exactly one cycle; spike_in_valid stays 0.
